lspc_vram_cpu_port: RTL

- CPU-side initiator for LSPC VRAM accesses; produces the requests that the slow and fast VRAM cycle blocks consume.
- Holds REG_VRAMADDR and REG_VRAMMOD and a one-deep write holding buffer.
- Drives VRAM_ADDR, VRAM_WRITE, REG_VRAMADDR_MSB and nVRAM_WRITE_REQ, then waits for the owning cycle block to report completion.
- On completion it advances the address by the modulo. It also provides CPU read data selected from the low (slow) or high (fast) VRAM read latches.

---
 rtl/lspc_pkg.sv | 22 ++
 rtl/lspc_ack_edge.sv | 26 ++
 rtl/lspc_vram_cpu_port.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/lspc_pkg.sv
// Shared types and constants for the LSPC VRAM CPU port.
package lspc_pkg;

   localparam int VRAM_ADDR_W   = 16;
   localparam int VRAM_DATA_W   = 16;
   localparam int FAST_VRAM_MSB = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_INC  = 2'd2
   } lspc_state_e;

   // Advance within the current VRAM region; the region bit never changes.
   function automatic logic [VRAM_ADDR_W-1:0] vram_addr_advance(
      input logic [VRAM_ADDR_W-1:0]   addr,
      input logic [FAST_VRAM_MSB-1:0] modv
   );
      return {addr[FAST_VRAM_MSB], addr[FAST_VRAM_MSB-1:0] + modv};
   endfunction

endpackage

// File: rtl/lspc_ack_edge.sv
// Registered rising-edge detector for an active-low write-completion strobe.
module lspc_ack_edge (
   input  logic clk,
   input  logic resetp,
   input  logic level,
   output logic ack
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = level;
   end

   always_ff @(posedge clk) begin
      if (!resetp) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign ack = level & ~prev_q;

endmodule

// File: rtl/lspc_vram_cpu_port.sv
// CPU-side VRAM request initiator with modulo address advance and read settle.
// Optional request timeout/abort is enabled with LSPC_VRAM_TIMEOUT_EN.
module lspc_vram_cpu_port
   import lspc_pkg::*;
#(
   parameter int READ_SETTLE = 48
`ifdef LSPC_VRAM_TIMEOUT_EN
   , parameter int TIMEOUT = 4096
`endif
) (
   input  logic                   CLK,
   input  logic                   RESETP,
   input  logic                   REG_WR_ADDR,
   input  logic                   REG_WR_DATA,
   input  logic                   REG_WR_MOD,
   input  logic [VRAM_DATA_W-1:0] CPU_DATA,
   input  logic                   nCPU_WR_LOW,
   input  logic                   nCPU_WR_HIGH,
   input  logic [VRAM_DATA_W-1:0] VRAM_LOW_READ,
   input  logic [VRAM_DATA_W-1:0] VRAM_HIGH_READ,
   output logic [VRAM_ADDR_W-1:0] VRAM_ADDR,
   output logic [VRAM_DATA_W-1:0] VRAM_WRITE,
   output logic                   REG_VRAMADDR_MSB,
   output logic                   nVRAM_WRITE_REQ,
   output logic [VRAM_DATA_W-1:0] CPU_RD_DATA,
   output logic                   CPU_RD_VALID,
   output logic                   CPU_BUSY,
   output logic                   OVERRUN
);

   localparam int SW = $clog2(READ_SETTLE + 1);

   lspc_state_e                state_q, state_d;
   logic [VRAM_ADDR_W-1:0]     addr_q, addr_d;
   logic [FAST_VRAM_MSB-1:0]   mod_q, mod_d;
   logic [VRAM_DATA_W-1:0]     wdata_q, wdata_d;
   logic [VRAM_DATA_W-1:0]     pend_data_q, pend_data_d;
   logic                       pend_full_q, pend_full_d;
   logic                       req_msb_q, req_msb_d;
   logic                       nreq_q, nreq_d;
   logic                       overrun_q, overrun_d;
   logic [SW-1:0]              settle_q, settle_d;
   logic                       ack_low_s, ack_high_s, ack_sel_s, busy_s, abort_s;
`ifdef LSPC_VRAM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT);
   logic [TW-1:0]              to_q, to_d;
`endif

   lspc_ack_edge u_ack_low  (.clk(CLK), .resetp(RESETP), .level(nCPU_WR_LOW),  .ack(ack_low_s));
   lspc_ack_edge u_ack_high (.clk(CLK), .resetp(RESETP), .level(nCPU_WR_HIGH), .ack(ack_high_s));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      mod_d       = mod_q;
      wdata_d     = wdata_q;
      pend_data_d = pend_data_q;
      pend_full_d = pend_full_q;
      req_msb_d   = req_msb_q;
      nreq_d      = nreq_q;
      overrun_d   = overrun_q;
      settle_d    = settle_q;
      abort_s     = 1'b0;
`ifdef LSPC_VRAM_TIMEOUT_EN
      to_d        = (state_q == ST_REQ) ? to_q + TW'(1) : TW'(0);
`endif
      busy_s      = (state_q != ST_IDLE) | pend_full_q;
      if (req_msb_q) begin
         ack_sel_s = ack_high_s;
      end else begin
         ack_sel_s = ack_low_s;
      end

      if (settle_q != SW'(0)) begin
         settle_d = settle_q - SW'(1);
      end else begin
         settle_d = settle_q;
      end

      // Register loads precede the FSM so a same-cycle data write sees the new address.
      if (REG_WR_ADDR) begin
         if (!busy_s) begin
            addr_d   = CPU_DATA;
            settle_d = SW'(READ_SETTLE);
         end else begin
            overrun_d = 1'b1;
         end
      end else begin
         addr_d = addr_q;
      end
      if (REG_WR_MOD) begin
         if (!busy_s) begin
            mod_d = CPU_DATA[FAST_VRAM_MSB-1:0];
         end else begin
            overrun_d = 1'b1;
         end
      end else begin
         mod_d = mod_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (REG_WR_DATA) begin
               wdata_d   = CPU_DATA;
               req_msb_d = addr_d[FAST_VRAM_MSB];
               nreq_d    = 1'b0;
               state_d   = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (ack_sel_s) begin
               nreq_d  = 1'b1;
               state_d = ST_INC;
`ifdef LSPC_VRAM_TIMEOUT_EN
            end else if (to_q == TW'(TIMEOUT - 1)) begin
               abort_s     = 1'b1;
               nreq_d      = 1'b1;
               pend_full_d = 1'b0;
               overrun_d   = 1'b1;
               to_d        = TW'(0);
               state_d     = ST_IDLE;
`endif
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_INC: begin
            addr_d   = vram_addr_advance(addr_q, mod_q);
            settle_d = SW'(READ_SETTLE);
            if (pend_full_q) begin
               wdata_d     = pend_data_q;
               pend_full_d = 1'b0;
               nreq_d      = 1'b0;
               state_d     = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            nreq_d  = 1'b1;
            state_d = ST_IDLE;
         end
      endcase

      // A slot freed by INC this cycle can take the new write without overrun.
      if (REG_WR_DATA && (state_q != ST_IDLE) && !abort_s) begin
         if (pend_full_d) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_d;
         end
         pend_data_d = CPU_DATA;
         pend_full_d = 1'b1;
      end else begin
         pend_data_d = pend_data_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETP) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         mod_q       <= '0;
         wdata_q     <= '0;
         pend_data_q <= '0;
         pend_full_q <= 1'b0;
         req_msb_q   <= 1'b0;
         nreq_q      <= 1'b1;
         overrun_q   <= 1'b0;
         settle_q    <= '0;
`ifdef LSPC_VRAM_TIMEOUT_EN
         to_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         mod_q       <= mod_d;
         wdata_q     <= wdata_d;
         pend_data_q <= pend_data_d;
         pend_full_q <= pend_full_d;
         req_msb_q   <= req_msb_d;
         nreq_q      <= nreq_d;
         overrun_q   <= overrun_d;
         settle_q    <= settle_d;
`ifdef LSPC_VRAM_TIMEOUT_EN
         to_q        <= to_d;
`endif
      end
   end

   assign VRAM_ADDR        = addr_q;
   assign VRAM_WRITE       = wdata_q;
   assign REG_VRAMADDR_MSB = addr_q[FAST_VRAM_MSB];
   assign nVRAM_WRITE_REQ  = nreq_q;
   assign CPU_RD_DATA      = addr_q[FAST_VRAM_MSB] ? VRAM_HIGH_READ : VRAM_LOW_READ;
   assign CPU_RD_VALID     = (settle_q == SW'(0));
   assign CPU_BUSY         = (state_q != ST_IDLE) | pend_full_q;
   assign OVERRUN          = overrun_q;

endmodule
